mips_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the shared MIPS datapath (PC, instruction register, register file, ALU, unified memory) one phase per clock. It replaces the single-cycle combinational decoder so that one memory port and one ALU serve fetch, address calculation and execute. It adds a memory ready handshake with timeout, plus a trap state for illegal opcodes and timeouts.

---
 rtl/mips_multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: one datapath phase per clock, memory ready
// handshake with a bounded wait, and a sticky trap for illegal opcodes/timeouts.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wait_inc;
    logic             mem_state;
    logic             wait_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Wait counter only advances while a memory phase is stalled; anything else clears it.
    always_comb begin
        mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        wait_inc     = wait_cnt_q + CNT_W'(1);
        wait_expired = !mem_ready && (wait_inc == TIMEOUT_CNT);
        wait_cnt_d   = (mem_state && !mem_ready) ? wait_inc : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)         state_d = S_DECODE;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)         state_d = S_MEM_WB;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)         state_d = S_FETCH;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // Moore decode of the state register; only FETCH/MEM_WR/BRANCH look at inputs.
    always_comb begin
        pc_en      = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'd2;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'd1;
                pc_src     = 2'd1;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'd2;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b1;
        endcase
        // A reset cycle must not commit a half-finished instruction.
        if (rst) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl plus hand-written
// sequences for trap hold, reset recovery and the memory wait timeout.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, instr_done, trap;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    // One cycle: inputs, expected state, expected {pc_en, ir_write, instr_done}.
    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       rdy;
        logic [3:0] st;
        logic [2:0] en;
    } vec_t;

    // Outputs that depend only on the state.
    typedef struct packed {
        logic [1:0] pc_src;
        logic       i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       trap;
    } stat_t;

    vec_t vecs[$];

    function automatic stat_t stat_of(input logic [3:0] s);
        stat_t r = '0;
        case (s)
            4'd0:  begin r.mem_read = 1'b1; r.src_b = 2'd1; end
            4'd1:  r.src_b = 2'd2;
            4'd2:  begin r.src_a = 1'b1; r.src_b = 2'd2; end
            4'd3:  begin r.i_or_d = 1'b1; r.mem_read = 1'b1; end
            4'd4:  begin r.mem_to_reg = 1'b1; r.reg_write = 1'b1; end
            4'd5:  begin r.i_or_d = 1'b1; r.mem_write = 1'b1; end
            4'd6:  begin r.src_a = 1'b1; r.alu_op = 2'd2; end
            4'd7:  begin r.reg_dst = 1'b1; r.reg_write = 1'b1; end
            4'd8:  begin r.src_a = 1'b1; r.alu_op = 2'd1; r.pc_src = 2'd1; end
            4'd9:  r.pc_src = 2'd2;
            4'd10: begin r.src_a = 1'b1; r.src_b = 2'd2; end
            4'd11: r.reg_write = 1'b1;
            4'd12: r.trap = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [2:0] en);
        vecs.push_back('{rst: r, op: op, zero: z, rdy: rdy, st: st, en: en});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        stat_t exp_s, got_s;
        rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;

        // R-type, ready tied high: 0,1,6,7
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b000000, 0, 1, 4'd1,  3'b000);
        add(0, 6'b000000, 0, 1, 4'd6,  3'b000);
        add(0, 6'b000000, 0, 1, 4'd7,  3'b001);
        // addi: 0,1,10,11
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b001000, 0, 1, 4'd1,  3'b000);
        add(0, 6'b001000, 0, 1, 4'd10, 3'b000);
        add(0, 6'b001000, 0, 1, 4'd11, 3'b001);
        // lw with three wait cycles in MEM_RD
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b100011, 0, 0, 4'd1,  3'b000);
        add(0, 6'b100011, 0, 0, 4'd2,  3'b000);
        add(0, 6'b100011, 0, 0, 4'd3,  3'b000);
        add(0, 6'b100011, 0, 0, 4'd3,  3'b000);
        add(0, 6'b100011, 0, 0, 4'd3,  3'b000);
        add(0, 6'b100011, 0, 1, 4'd3,  3'b000);
        add(0, 6'b100011, 0, 1, 4'd4,  3'b001);
        // sw, zero wait
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b101011, 0, 1, 4'd1,  3'b000);
        add(0, 6'b101011, 0, 1, 4'd2,  3'b000);
        add(0, 6'b101011, 0, 1, 4'd5,  3'b001);
        // beq taken, then not taken
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b000100, 1, 1, 4'd1,  3'b000);
        add(0, 6'b000100, 1, 1, 4'd8,  3'b101);
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b000100, 0, 1, 4'd1,  3'b000);
        add(0, 6'b000100, 0, 1, 4'd8,  3'b001);
        // j with mem_ready low outside memory phases
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b000010, 0, 0, 4'd1,  3'b000);
        add(0, 6'b000010, 0, 0, 4'd9,  3'b101);
        // sw stalled in MEM_WR, reset arrives with ready
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        add(0, 6'b101011, 0, 1, 4'd1,  3'b000);
        add(0, 6'b101011, 0, 0, 4'd2,  3'b000);
        add(0, 6'b101011, 0, 0, 4'd5,  3'b000);
        add(0, 6'b101011, 0, 0, 4'd5,  3'b000);
        add(1, 6'b101011, 0, 1, 4'd5,  3'b000);
        add(0, 6'b101011, 0, 0, 4'd0,  3'b000);
        add(0, 6'b000000, 0, 1, 4'd0,  3'b110);
        // illegal opcode
        add(0, 6'b111111, 0, 1, 4'd1,  3'b000);
        add(0, 6'b111111, 0, 1, 4'd12, 3'b000);
        add(0, 6'b111111, 0, 1, 4'd12, 3'b000);

        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            exp_s = stat_of(vecs[i].st);
            if (vecs[i].rst) begin
                exp_s.mem_write = 1'b0;
                exp_s.reg_write = 1'b0;
            end
            got_s = {pc_src, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                     alu_src_a, alu_src_b, alu_op, trap};
            chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("row%0d enables", i), 32'({pc_en, ir_write, instr_done}), 32'(vecs[i].en));
            chk($sformatf("row%0d decode", i), 32'(got_s), 32'(exp_s));
            chk($sformatf("row%0d onehot_wr", i),
                32'($countones({reg_write, mem_write, ir_write}) <= 1), 32'd1);
            @(negedge clk);
        end

        // TRAP holds with every enable low regardless of inputs
        for (int k = 0; k < 22; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom_range(0, 63));
            #1;
            chk($sformatf("trap_hold%0d", k),
                32'({state, trap, pc_en, ir_write, reg_write, mem_write, mem_read, instr_done}),
                32'({4'd12, 1'b1, 6'b000000}));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        chk("trap_exit", 32'({state, trap}), 32'({4'd0, 1'b0}));

        // 15 wait cycles in FETCH, then TRAP
        for (int k = 0; k < 15; k++) begin
            #1;
            chk($sformatf("fetch_wait%0d", k), 32'({state, mem_read, i_or_d, pc_en}),
                32'({4'd0, 1'b1, 1'b0, 1'b0}));
            @(negedge clk);
        end
        #1;
        chk("timeout_trap", 32'(state), 32'd12);

        // ready on the 15th cycle completes the fetch instead
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("last_cycle_fetch", 32'({state, ir_write, pc_en}), 32'({4'd0, 1'b1, 1'b1}));
        @(negedge clk);
        #1;
        chk("last_cycle_decode", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
